// File: rtl/dq_decode_queue.sv
// dq_decode_queue: decodes DQ-form lq / lxv / stxv into uops and buffers them
// in an in-order FIFO between predecode and load-store issue.
// Optional build macro: DQ_CRACK_QUAD_EN (split a legal lq into two uops).
module dq_decode_queue #(
    parameter int instructionWidth = 32,
    parameter int addressSize      = 64,
    parameter int opcodeWidth      = 6,
    parameter int regWidth         = 5,
    parameter int DEPTH            = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [instructionWidth-1:0] instruction_i,
    input  logic [addressSize-1:0]      address_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [opcodeWidth-1:0]      opcode_o,
    output logic [1:0]                  kind_o,
    output logic [regWidth:0]           reg1_o,
    output logic [regWidth-1:0]         reg2_o,
    output logic                        reg2ValOrZero_o,
    output logic [63:0]                 imm_o,
    output logic [addressSize-1:0]      address_o,
    output logic                        illegal_o,
    output logic                        last_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    // Instruction bits are numbered 0..31 MSB-first; bit k lives at [IM-k].
    localparam int IM = instructionWidth - 1;

    typedef enum logic {IDLE, SECOND} state_e;

    typedef struct packed {
        logic [opcodeWidth-1:0] opcode;
        logic [1:0]             kind;
        logic [regWidth:0]      reg1;
        logic [regWidth-1:0]    reg2;
        logic [63:0]            imm;
        logic [addressSize-1:0] address;
        logic                   illegal;
        logic                   last;
    } uop_t;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    uop_t            mem_q [DEPTH];
    uop_t            mem_d [DEPTH];
`ifdef DQ_CRACK_QUAD_EN
    uop_t            pend_q, pend_d;
`endif

    logic [opcodeWidth-1:0] dec_opc;
    logic [regWidth-1:0]    dec_rt;
    logic [regWidth-1:0]    dec_ra;
    logic [11:0]            dec_dq;
    logic [3:0]             dec_low;
    logic [15:0]            dec_imm16;
    logic                   dec_is_lq;
    logic                   dec_is_stxv;
    logic                   dec_hit;
    uop_t                   dec_uop;

    uop_t                   head;
    logic                   head_valid;
    logic                   push;
    logic                   pop;
    uop_t                   push_uop;

    // Decode the offered instruction into a single candidate uop.
    always_comb begin
        dec_opc     = instruction_i[IM -: opcodeWidth];
        dec_rt      = instruction_i[IM-6 -: regWidth];
        dec_ra      = instruction_i[IM-11 -: regWidth];
        dec_dq      = instruction_i[IM-16 -: 12];
        dec_low     = instruction_i[IM-28 -: 4];
        dec_imm16   = {dec_dq, 4'b0000};
        dec_is_lq   = (dec_opc == opcodeWidth'(56));
        dec_is_stxv = (dec_opc == opcodeWidth'(61)) && (dec_low[2:0] == 3'd5);
        dec_hit     = dec_is_lq || dec_is_stxv ||
                      ((dec_opc == opcodeWidth'(61)) && (dec_low[2:0] == 3'd1));
        dec_uop         = '0;
        dec_uop.opcode  = dec_opc;
        dec_uop.reg2    = dec_ra;
        dec_uop.imm     = {{48{dec_imm16[15]}}, dec_imm16};
        dec_uop.address = address_i;
        dec_uop.last    = 1'b1;
        if (dec_is_lq) begin
            dec_uop.kind    = 2'd0;
            dec_uop.reg1    = {1'b0, dec_rt};
            dec_uop.illegal = dec_rt[0] || (dec_rt == dec_ra) || (dec_low != 4'b0000);
        end else begin
            dec_uop.kind = dec_is_stxv ? 2'd2 : 2'd1;
            dec_uop.reg1 = {dec_low[3], dec_rt};
        end
    end

    // Present the FIFO head; data outputs read as zero while empty.
    always_comb begin
        head_valid      = (count_q != '0);
        head            = mem_q[rd_ptr_q];
        valid_o         = head_valid;
        reg2ValOrZero_o = 1'b1;
        opcode_o        = '0;
        kind_o          = '0;
        reg1_o          = '0;
        reg2_o          = '0;
        imm_o           = '0;
        address_o       = '0;
        illegal_o       = 1'b0;
        last_o          = 1'b0;
        if (head_valid) begin
            opcode_o  = head.opcode;
            kind_o    = head.kind;
            reg1_o    = head.reg1;
            reg2_o    = head.reg2;
            imm_o     = head.imm;
            address_o = head.address;
            illegal_o = head.illegal;
            last_o    = head.last;
        end
    end

    // Handshake, crack sequencing and FIFO pointer/count next-state.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        push     = 1'b0;
        push_uop = dec_uop;
`ifdef DQ_CRACK_QUAD_EN
        pend_d   = pend_q;
`endif
        ready_o = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !flush_i;
        pop     = head_valid && ready_i;

        if (valid_i && ready_o && dec_hit) begin
            push = 1'b1;
`ifdef DQ_CRACK_QUAD_EN
            if (dec_is_lq && !dec_uop.illegal) begin
                push_uop.last = 1'b0;
                pend_d        = dec_uop;
                pend_d.reg1   = dec_uop.reg1 + (regWidth+1)'(1);
                pend_d.imm    = dec_uop.imm + 64'd8;
                state_d       = SECOND;
            end
`endif
        end

`ifdef DQ_CRACK_QUAD_EN
        // ready_o is low in SECOND, so this never collides with an accept.
        if ((state_q == SECOND) && (count_q < CW'(DEPTH))) begin
            push     = 1'b1;
            push_uop = pend_q;
            state_d  = IDLE;
        end
`endif

        if (push) begin
            mem_d[wr_ptr_q] = push_uop;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = IDLE;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef DQ_CRACK_QUAD_EN
    // Pending second uop of a cracked lq.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    // FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/dq_decode_queue.md
Name: dq_decode_queue

Overview:
- Registered DQ-form decoder with valid/ready handshakes on both sides and a parametrised uop FIFO.
- Sits between fetch/predecode and the load-store issue stage.
- Decodes lq (op 56), lxv (op 61, XO=1) and stxv (op 61, XO=5), forms full VSX register numbers, and flags invalid forms.
- Buffers decoded uops so load-store backpressure does not stall the decode front end.

Parameters:
- instructionWidth, 32, instruction word width.
- addressSize, 64, instruction address width.
- opcodeWidth, 6, primary opcode width.
- regWidth, 5, GPR field width; VSX target uses regWidth+1.
- DEPTH, 4, uop FIFO entries; power of two, at least 2.

Ports:
- clock_i, in, 1, rising-edge clock.
- reset_n_i, in, 1, reset: asynchronous, active-low.
- flush_i, in, 1, synchronous flush of the FIFO and crack state.
- valid_i, in, 1, instruction_i/address_i valid.
- ready_o, out, 1, block accepts the input this cycle.
- instruction_i, in, instructionWidth, instruction bits 0:31, MSB-first.
- address_i, in, addressSize, instruction address.
- valid_o, out, 1, FIFO head valid.
- ready_i, in, 1, consumer pops the head.
- opcode_o, out, opcodeWidth, primary opcode.
- kind_o, out, 2, 0 = lq, 1 = lxv, 2 = stxv.
- reg1_o, out, regWidth+1, target/source: lq {0,RT}; lxv/stxv {TX,T}.
- reg2_o, out, regWidth, RA.
- reg2ValOrZero_o, out, 1, always 1: RA=0 means literal zero.
- imm_o, out, 64, sign-extended {DQ,4'b0000}.
- address_o, out, addressSize, instruction address of the uop.
- illegal_o, out, 1, invalid instruction form.
- last_o, out, 1, final uop of the instruction.

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, count=0, FSM=IDLE, valid_o=0, all data outputs 0, ready_o=1.
- Handshake: transfer on valid_i&&ready_o. Pop on valid_o&&ready_i.
- Backpressure: ready_o = (FSM==IDLE) && (count<DEPTH) && !flush_i. A pop in the same cycle does not free a slot for the input; ready_o has no comb path from ready_i.
- Decode on accept:
  - Op 56 → lq.
  - Op 61 with bits 29:31 = 1 → lxv; = 5 → stxv.
  - Any other instruction: consumed (ready_o honoured), nothing pushed.
- Illegal lq: RT odd, or RT==RA, or bits 28:31 ≠ 0. Push one uop with illegal_o=1, last_o=1, no cracking.
- Field extraction: imm_o = $signed({instr[16:27],4'b0000}) extended to 64. For lxv/stxv, TX = instr[28].
- Latency: a push at edge N makes valid_o=1 after edge N (head visible next cycle). FIFO is in-order.
- FIFO pointers wrap modulo DEPTH. Push and pop in the same cycle with count>0 leaves count unchanged. count never exceeds DEPTH; count never underflows.
- Flush: clears count, pointers and FSM. valid_o=0 the next cycle. Same-cycle input is not accepted.
- Reset mid-crack returns to IDLE and discards the pending second uop.
- FSM: IDLE, SECOND. SECOND exists only with the optional feature; without it, FSM stays IDLE.

Optional Feature:
- Macro: DQ_CRACK_QUAD_EN.
- Defined:
  - A legal lq cracks into two uops.
  - First uop: reg1_o={0,RT}, imm, last_o=0. Pushed on accept; FSM→SECOND.
  - Second uop: reg1_o={0,RT+1}, imm+8, last_o=1. Pushed on the first cycle in SECOND with count<DEPTH; FSM→IDLE.
  - ready_o=0 while in SECOND.
  - Both uops carry the same address_o.
- Undefined: lq emits one uop with last_o=1. kind_o and imm are unchanged.

Test Plan:
- lq r4,32(r3) (0xE0830020), ready_i=1 → one cycle later: kind_o=0, reg1_o=4, reg2_o=3, imm_o=0x20, last_o=1 (cracked: second uop reg1_o=5, imm_o=0x28).
- lxv with TX=1, T=2, RA=0, DQ=-1 → reg1_o=34, reg2_o=0, imm_o=0xFFFF_FFFF_FFFF_FFF0, reg2ValOrZero_o=1.
- lq with RT=5, then lq with RT==RA → each yields exactly one uop, illegal_o=1, last_o=1.
- ready_i=0, push DEPTH+1 valid instructions → ready_o drops after DEPTH pushes. Raise ready_i → FIFO drains in order; no loss, no duplication.
- Non-DQ opcode 31 offered → accepted, FIFO count unchanged, valid_o stays 0.
- With FIFO full and FSM in SECOND, assert flush_i → next cycle valid_o=0, ready_o=1; no stale second uop appears.
